// File: rtl/ifq_pkg.sv
// Shared types, default sizes and sizing helpers for the instruction fetch queue.
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PAUSE = 2'd2
    } ifq_state_e;

    localparam int IFQ_ADDR_W = 32;
    localparam int IFQ_INST_W = 32;
    localparam int IFQ_DEPTH  = 4;

    function automatic int pc_step(input int inst_w);
        return inst_w / 8;
    endfunction

    localparam int PC_STEP = pc_step(IFQ_INST_W);

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush, full/empty/count; storage is left unreset, only pointers and count are.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential PC requests, in-order response queue, redirect with stale discard.
// Optional IFQ_BYPASS_EN: a response arriving at an empty queue is presented to decode in the same cycle.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                ADDR_W   = IFQ_ADDR_W,
    parameter int                INST_W   = IFQ_INST_W,
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int                CW   = cnt_w(DEPTH);
    localparam int                QW   = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(pc_step(INST_W));

    ifq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [QW-1:0]     last_q;

    logic              grant, rsp_ok, rsp_keep, bypass;
    logic              q_push, q_pop, q_full, q_empty;
    logic              tag_full, tag_empty;
    logic [CW-1:0]     q_count, inflight, inflight_next;
    logic [QW-1:0]     q_rdata, out_word;
    logic [ADDR_W-1:0] tag_pc;

    // Credit rule: every outstanding request already owns a queue slot, so the queue cannot overflow.
    assign mem_req  = (state_q == FETCH) && fetch_en &&
                      (({1'b0, q_count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
    assign mem_addr = pc_q;
    assign grant    = mem_req && mem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok        = mem_rvalid && !tag_empty;
    assign rsp_keep      = rsp_ok && (discard_q == '0) && !redirect_valid;
    assign inflight_next = inflight + CW'(grant) - CW'(rsp_ok);

`ifdef IFQ_BYPASS_EN
    assign bypass = q_empty && rsp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid        = !q_empty || bypass;
    assign out_word          = !q_empty ? q_rdata : (bypass ? {tag_pc, mem_rdata} : last_q);
    assign {inst_pc, inst}   = out_word;
    assign q_pop             = !q_empty && inst_ready && !redirect_valid;
    assign q_push            = rsp_keep && !(bypass && inst_ready);

    ifq_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (grant),
        .pop_i   (rsp_ok),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (inflight)
    );

    ifq_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .wdata_i ({tag_pc, mem_rdata}),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (!fetch_en) state_d = PAUSE;
            PAUSE:   if (fetch_en) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Redirect wins: everything still outstanding after this cycle is stale and must be dropped.
    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            discard_d = inflight_next;
        end else begin
            if (grant) pc_d = pc_q + STEP;
            if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            if (inst_valid) last_q <= out_word;
        end
    end

    a_rvalid_with_inflight: assert property (@(posedge clk) disable iff (!reset)
        !(mem_rvalid && tag_empty));
    a_no_queue_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(q_push && q_full && !q_pop));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(grant && tag_full));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed scenarios, then a randomised phase against a PC-stream reference model.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 4;
`ifdef IFQ_BYPASS_EN
    localparam int          LAT      = 0;
`else
    localparam int          LAT      = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, fetch_en, mem_req, mem_gnt, mem_rvalid;
    logic        redirect_valid, inst_valid, inst_ready;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    int          checks   = 0;
    int          failures = 0;
    word_t       exp_q[$];
    logic [31:0] mem_pend[$];
    logic [31:0] model_pc = RESET_PC;
    logic        prev_fen = 1'b0;
    int          gnt_cnt  = 0;
    int          rsp_pct  = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE2803006;
        if (a == 32'h4) return 32'hEA000004;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Request side: the decode stream must be the PC sequence restarted at every redirect.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
        end else begin
            if (mem_req && mem_gnt) begin
                gnt_cnt++;
                mem_pend.push_back(mem_addr);
            end
            if (!fetch_en && !prev_fen) chk("req_while_paused", mem_req, 1'b0);
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc;
            end else if (mem_req && mem_gnt) begin
                chk("req_addr", mem_addr, model_pc);
                exp_q.push_back(word_t'{pc: model_pc, inst: mem_word(model_pc)});
                model_pc = model_pc + 32'(PC_STEP);
            end
        end
        prev_fen = fetch_en;
    end

    // Decode side monitor.
    always @(negedge clk) begin
        word_t w;
        if (reset && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got pc=%0h inst=%0h, expected no word", inst_pc, inst);
            end else begin
                w = exp_q.pop_front();
                chk("inst_pc", inst_pc, w.pc);
                chk("inst", inst, w.inst);
            end
        end
    end

    // Memory: in-order responses, at least one cycle after the grant.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                mem_pend.delete();
                mem_rvalid = 1'b0;
            end else if (mem_pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(mem_pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        fetch_en       = 1'b0;
        mem_gnt        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_pct        = 100;
        repeat (3) tick();
    endtask

    task automatic grant_n(input int n);
        gnt_cnt = 0;
        mem_gnt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt_cnt >= n) break;
        end
        mem_gnt = 1'b0;
        chk("grant_count", gnt_cnt, n);
    endtask

    initial begin
        int t_rv, t_iv;

        // Reset state
        do_reset();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Streaming fetch with 1-cycle memory
        reset = 1'b1; fetch_en = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
        tick();
        chk("first_req", mem_req, 1'b1);
        chk("first_addr", mem_addr, RESET_PC);
        t_rv = -1;
        t_iv = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_rv < 0 && mem_rvalid) t_rv = i;
            if (t_iv < 0 && inst_valid) t_iv = i;
        end
        chk("rsp_to_valid_latency", t_iv - t_rv, LAT);

        // Decode stalled: credit limit, then resume at 0x10
        do_reset();
        reset = 1'b1; fetch_en = 1'b1; mem_gnt = 1'b1;
        gnt_cnt = 0;
        repeat (15) tick();
        chk("stall_grants", gnt_cnt, DEPTH);
        chk("stall_req_off", mem_req, 1'b0);
        chk("stall_inst_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) break;
            tick();
        end
        chk("resume_addr", mem_addr, 32'h10);
        repeat (10) tick();

        // Redirect with two responses outstanding
        do_reset();
        reset = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1; rsp_pct = 0;
        tick();
        grant_n(2);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h18; rsp_pct = 100;
        tick();
        redirect_valid = 1'b0; mem_gnt = 1'b1;
        chk("redir_addr", mem_addr, 32'h18);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        chk("redir_first_pc", inst_pc, 32'h18);
        chk("redir_first_inst", inst, mem_word(32'h18));
        repeat (5) tick();

        // Redirect coinciding with a grant and a response
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        chk("coinc_req_rvalid", {mem_req, mem_rvalid}, 2'b11);
        tick();
        redirect_valid = 1'b0;
        chk("coinc_addr", mem_addr, 32'h100);
        chk("coinc_empty", inst_valid, 1'b0);
        repeat (6) tick();

        // PC wrap, then pause with draining
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_start", mem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_addr != 32'hFFFF_FFFC) break;
        end
        chk("wrap_addr", mem_addr, 32'h0);
        fetch_en = 1'b0;
        repeat (12) tick();
        chk("pause_req", mem_req, 1'b0);
        chk("pause_drained", inst_valid, 1'b0);
        chk("pause_sb_empty", exp_q.size(), 0);

        // Asynchronous reset with three words queued
        do_reset();
        reset = 1'b1; fetch_en = 1'b1;
        tick();
        grant_n(3);
        repeat (4) tick();
        chk("pre_reset_valid", inst_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", inst_valid, 1'b0);
        chk("async_rst_addr", mem_addr, RESET_PC);
        chk("async_rst_req", mem_req, 1'b0);

        // Randomised traffic
        do_reset();
        reset = 1'b1; rsp_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            tick();
            fetch_en       = ($urandom_range(99) < 90);
            mem_gnt        = ($urandom_range(99) < 70);
            inst_ready     = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
        end
        tick();
        fetch_en = 1'b0; mem_gnt = 1'b0; redirect_valid = 1'b0;
        inst_ready = 1'b1; rsp_pct = 100;
        repeat (40) tick();
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_mem_idle", mem_pend.size(), 0);
        chk("final_inst_valid", inst_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
